// File: rtl/cpx_grant_pipe_pkg.sv
// Shared definitions for the CPX grant pipeline: default sizing, the
// grant-channel index map used by the arbiter, and the counter action type.
package cpx_grant_pipe_pkg;

  // Default sizing, matching the legacy fixed 8-channel single-stage block.
  localparam int NCH_DEF    = 8;
  localparam int DEPTH_DEF  = 1;
  localparam int MAXOUT_DEF = 2;

  // CPX grant-channel indices; the arbiter and this block must agree on them.
  localparam int CPX_CH_C0 = 0;
  localparam int CPX_CH_C1 = 1;
  localparam int CPX_CH_C2 = 2;
  localparam int CPX_CH_C3 = 3;
  localparam int CPX_CH_C4 = 4;
  localparam int CPX_CH_C5 = 5;
  localparam int CPX_CH_C6 = 6;
  localparam int CPX_CH_C7 = 7;

  // Action taken by one outstanding-grant counter in a cycle.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // Width needed to hold 0..maxout inclusive.
  function automatic int cnt_width(input int maxout);
    return $clog2(maxout + 1);
  endfunction

endpackage

// File: rtl/cpx_grant_pipe_if.sv
// Grant/credit bus between the CCX arbiter (master) and the grant pipe (slave).
//
// Signalling: there is no valid/ready pair. grant_in, grant_out and credit_ret
// are single-cycle pulses, one bit per channel, sampled on every rising edge;
// any combination of bits may be set in one cycle. Flow control is by credit:
// the master must not issue a grant on channel i in a cycle where stall[i] is
// high. Grants already inside the pipe are never blocked; if they land on a
// full channel the sticky err_ovf flag is raised instead.
interface cpx_grant_pipe_if #(
  parameter int NCH = 8
);
  logic [NCH-1:0] grant_in;
  logic [NCH-1:0] credit_ret;
  logic [NCH-1:0] grant_out;
  logic [NCH-1:0] stall;
  logic           err_ovf;
  logic           err_unf;

  modport master (
    output grant_in,
    output credit_ret,
    input  grant_out,
    input  stall,
    input  err_ovf,
    input  err_unf
  );

  modport slave (
    input  grant_in,
    input  credit_ret,
    output grant_out,
    output stall,
    output err_ovf,
    output err_unf
  );
endinterface

// File: rtl/cpx_grant_cnt.sv
// Single-channel saturating up/down counter of outstanding grants.
// Never wraps: the count stays within 0..MAXOUT and the would-be overflow or
// underflow is reported as a one-cycle pulse instead.
module cpx_grant_cnt
  import cpx_grant_pipe_pkg::*;
#(
  parameter int MAXOUT = MAXOUT_DEF,
  parameter int CNTW   = cnt_width(MAXOUT)
) (
  input  logic            clk_i,
  input  logic            rst_l_i,
  input  logic            en_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CNTW-1:0] cnt_o,
  output logic            full_o,
  output logic            ovf_pulse_o,
  output logic            unf_pulse_o
);

  localparam logic [CNTW-1:0] MAX_C = CNTW'(MAXOUT);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            inc_e, dec_e, empty;
  cnt_op_e         op;

  // Gate both terms with the enable so the count freezes while disabled.
  assign inc_e  = en_i & inc_i;
  assign dec_e  = en_i & dec_i;
  assign full_o = (cnt_q == MAX_C);
  assign empty  = (cnt_q == '0);

  // A grant and a credit in the same cycle cancel; otherwise move one step
  // unless that would leave 0..MAXOUT.
  always_comb begin
    op = CNT_HOLD;
    if (inc_e && !dec_e && !full_o) begin
      op = CNT_INC;
    end else if (dec_e && !inc_e && !empty) begin
      op = CNT_DEC;
    end
  end

  // Next count from the selected action.
  always_comb begin
    cnt_d = cnt_q;
    case (op)
      CNT_INC: cnt_d = cnt_q + CNTW'(1);
      CNT_DEC: cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_l_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign ovf_pulse_o = inc_e & !dec_e & full_o;
  assign unf_pulse_o = dec_e & !inc_e & empty;

endmodule

// File: rtl/cpx_grant_pipe.sv
// CPX grant pipeline: delays the arbiter grant vector by DEPTH stages, keeps
// a per-channel count of outstanding grants (returned by credit pulses),
// drives per-channel stall and sticky overflow/underflow flags. The pipeline
// flops double as one serial scan chain when se is high.
module cpx_grant_pipe
  import cpx_grant_pipe_pkg::*;
#(
  parameter  int NCH    = NCH_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  parameter  int MAXOUT = MAXOUT_DEF,
  localparam int CNTW   = cnt_width(MAXOUT)
) (
  input  logic                 rclk,
  input  logic                 rst_l,
  input  logic                 se,
  input  logic                 si,
  output logic                 so,
  cpx_grant_pipe_if.slave      bus,
  output logic [NCH*CNTW-1:0]  cnt_dbg_o
);

  // Stage k, channel j lives at chain bit k*NCH+j, so stage 0 is at the
  // bottom and the last stage at the top. This one flat vector serves both
  // as the grant pipe and as the scan chain si -> bit 0 -> ... -> top bit.
  localparam int CHAIN_W = NCH * DEPTH;

  logic [CHAIN_W-1:0] chain_q, chain_d;
  logic [NCH-1:0]     stall_vec;
  logic [NCH-1:0]     ovf_vec;
  logic [NCH-1:0]     unf_vec;
  logic [NCH*CNTW-1:0] cnt_vec;
  logic               err_ovf_q, err_unf_q;

  // Shift the chain by one channel-vector (normal) or by one bit (scan);
  // the bits pushed off the top are discarded by the truncating cast.
  always_comb begin
    chain_d = chain_q;
    if (se) begin
      chain_d = CHAIN_W'({chain_q, si});
    end else begin
      chain_d = CHAIN_W'({chain_q, bus.grant_in});
    end
  end

  // Pipeline / scan flops; reset wins over scan and drops in-flight grants.
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign bus.grant_out = chain_q[CHAIN_W-1 -: NCH];
  assign so            = chain_q[CHAIN_W-1];

  // One outstanding-grant counter per channel; frozen while scanning.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    cpx_grant_cnt #(
      .MAXOUT (MAXOUT),
      .CNTW   (CNTW)
    ) u_cnt (
      .clk_i       (rclk),
      .rst_l_i     (rst_l),
      .en_i        (!se),
      .inc_i       (bus.grant_out[i]),
      .dec_i       (bus.credit_ret[i]),
      .cnt_o       (cnt_vec[i*CNTW +: CNTW]),
      .full_o      (stall_vec[i]),
      .ovf_pulse_o (ovf_vec[i]),
      .unf_pulse_o (unf_vec[i])
    );
  end

  // Sticky error flags, ORed across channels, cleared only by reset.
  always_ff @(posedge rclk) begin
    if (!rst_l) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_q | (|ovf_vec);
      err_unf_q <= err_unf_q | (|unf_vec);
    end
  end

  assign bus.stall   = stall_vec;
  assign bus.err_ovf = err_ovf_q;
  assign bus.err_unf = err_unf_q;
  assign cnt_dbg_o   = cnt_vec;

endmodule

// File: tb/tb_cpx_grant_pipe.sv
// Directed bench for cpx_grant_pipe with NCH=8, DEPTH=3, MAXOUT=2.
module tb_cpx_grant_pipe;

  localparam int NCH    = 8;
  localparam int DEPTH  = 3;
  localparam int MAXOUT = 2;
  localparam int CNTW   = 2;
  localparam int CHAIN  = NCH * DEPTH;

  logic                rclk;
  logic                rst_l;
  logic                se;
  logic                si;
  logic                so;
  logic [NCH*CNTW-1:0] cnt_dbg;

  int checks;
  int errors;

  cpx_grant_pipe_if #(.NCH(NCH)) bus ();

  cpx_grant_pipe #(
    .NCH    (NCH),
    .DEPTH  (DEPTH),
    .MAXOUT (MAXOUT)
  ) dut (
    .rclk      (rclk),
    .rst_l     (rst_l),
    .se        (se),
    .si        (si),
    .so        (so),
    .bus       (bus),
    .cnt_dbg_o (cnt_dbg)
  );

  // Clock
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Advance one edge and settle; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    se = 1'b0;
    si = 1'b0;
    bus.grant_in = '0;
    bus.credit_ret = '0;
    tick();
    tick();
    rst_l = 1'b1;
    checks++;
    if (bus.grant_out !== 8'h00) begin
      errors++; $display("FAIL reset_grant_out got %h exp 00", bus.grant_out);
    end
    checks++;
    if (bus.stall !== 8'h00) begin
      errors++; $display("FAIL reset_stall got %h exp 00", bus.stall);
    end
    checks++;
    if ({bus.err_ovf, bus.err_unf} !== 2'b00) begin
      errors++; $display("FAIL reset_err got %b%b exp 00", bus.err_ovf, bus.err_unf);
    end
    checks++;
    if (so !== 1'b0) begin
      errors++; $display("FAIL reset_so got %b exp 0", so);
    end
    checks++;
    if (cnt_dbg !== 16'h0000) begin
      errors++; $display("FAIL reset_cnt got %h exp 0000", cnt_dbg);
    end
  endtask

  task automatic test_latency();
    logic [NCH-1:0] exp_go;
    bus.grant_in = 8'h81;
    for (int c = 1; c <= 5; c++) begin
      tick();
      bus.grant_in = 8'h00;
      exp_go = (c == 3) ? 8'h81 : 8'h00;
      checks++;
      if (bus.grant_out !== exp_go) begin
        errors++; $display("FAIL latency_c%0d got %h exp %h", c, bus.grant_out, exp_go);
      end
    end
    // Grant landed after edge 3, counted at edge 4: ch0 and ch7 at 1.
    checks++;
    if (cnt_dbg !== 16'h4001) begin
      errors++; $display("FAIL latency_cnt got %h exp 4001", cnt_dbg);
    end
    bus.credit_ret = 8'h81;
    tick();
    bus.credit_ret = 8'h00;
    checks++;
    if (cnt_dbg !== 16'h0000) begin
      errors++; $display("FAIL latency_drain got %h exp 0000", cnt_dbg);
    end
    checks++;
    if ({bus.err_ovf, bus.err_unf} !== 2'b00) begin
      errors++; $display("FAIL latency_err got %b%b exp 00", bus.err_ovf, bus.err_unf);
    end
  endtask

  task automatic test_saturation();
    bus.grant_in = 8'h04;
    tick();                 // E1
    tick();                 // E2
    bus.grant_in = 8'h00;
    tick();                 // E3: first grant at output
    tick();                 // E4: cnt2=1
    checks++;
    if (bus.stall !== 8'h00 || cnt_dbg !== 16'h0010) begin
      errors++; $display("FAIL sat_one stall %h cnt %h exp 00 0010", bus.stall, cnt_dbg);
    end
    tick();                 // E5: cnt2=2
    checks++;
    if (bus.stall !== 8'h04) begin
      errors++; $display("FAIL sat_stall got %h exp 04", bus.stall);
    end
    checks++;
    if (cnt_dbg !== 16'h0020) begin
      errors++; $display("FAIL sat_cnt got %h exp 0020", cnt_dbg);
    end
    bus.grant_in = 8'h04;
    tick();
    bus.grant_in = 8'h00;
    tick();
    tick();                 // third grant now at output
    checks++;
    if (bus.err_ovf !== 1'b0) begin
      errors++; $display("FAIL sat_ovf_early got %b exp 0", bus.err_ovf);
    end
    tick();
    checks++;
    if (bus.err_ovf !== 1'b1 || cnt_dbg !== 16'h0020) begin
      errors++; $display("FAIL sat_ovf ovf %b cnt %h exp 1 0020", bus.err_ovf, cnt_dbg);
    end
    bus.credit_ret = 8'h04;
    tick();
    bus.credit_ret = 8'h00;
    tick();
    tick();
    checks++;
    if (bus.err_ovf !== 1'b1 || cnt_dbg !== 16'h0010) begin
      errors++; $display("FAIL sat_sticky ovf %b cnt %h exp 1 0010", bus.err_ovf, cnt_dbg);
    end
    do_reset();
    checks++;
    if (bus.err_ovf !== 1'b0 || cnt_dbg !== 16'h0000) begin
      errors++; $display("FAIL sat_reset ovf %b cnt %h exp 0 0000", bus.err_ovf, cnt_dbg);
    end
  endtask

  task automatic test_simultaneous();
    bus.grant_in = 8'h20;
    tick();
    tick();
    bus.grant_in = 8'h00;
    tick();
    tick();
    tick();
    checks++;
    if (cnt_dbg !== 16'h0800 || bus.stall !== 8'h20) begin
      errors++; $display("FAIL simul_fill cnt %h stall %h exp 0800 20", cnt_dbg, bus.stall);
    end
    // Grant lands at full together with a credit.
    bus.grant_in = 8'h20;
    tick();
    bus.grant_in = 8'h00;
    tick();
    tick();
    bus.credit_ret = 8'h20;
    tick();
    bus.credit_ret = 8'h00;
    checks++;
    if (cnt_dbg !== 16'h0800 || bus.err_ovf !== 1'b0) begin
      errors++; $display("FAIL simul_full cnt %h ovf %b exp 0800 0", cnt_dbg, bus.err_ovf);
    end
    bus.credit_ret = 8'h20;
    tick();
    tick();
    bus.credit_ret = 8'h00;
    checks++;
    if (cnt_dbg !== 16'h0000) begin
      errors++; $display("FAIL simul_drain cnt %h exp 0000", cnt_dbg);
    end
    // Same at empty.
    bus.grant_in = 8'h20;
    tick();
    bus.grant_in = 8'h00;
    tick();
    tick();
    bus.credit_ret = 8'h20;
    tick();
    bus.credit_ret = 8'h00;
    checks++;
    if (cnt_dbg !== 16'h0000 || bus.err_unf !== 1'b0 || bus.err_ovf !== 1'b0) begin
      errors++; $display("FAIL simul_empty cnt %h unf %b ovf %b exp 0000 0 0", cnt_dbg, bus.err_unf, bus.err_ovf);
    end
  endtask

  task automatic test_underflow();
    bus.credit_ret = 8'h10;
    tick();
    bus.credit_ret = 8'h00;
    checks++;
    if (bus.err_unf !== 1'b1 || cnt_dbg !== 16'h0000) begin
      errors++; $display("FAIL unf_set unf %b cnt %h exp 1 0000", bus.err_unf, cnt_dbg);
    end
    tick();
    tick();
    checks++;
    if (bus.err_unf !== 1'b1) begin
      errors++; $display("FAIL unf_sticky got %b exp 1", bus.err_unf);
    end
    do_reset();
    checks++;
    if (bus.err_unf !== 1'b0) begin
      errors++; $display("FAIL unf_reset got %b exp 0", bus.err_unf);
    end
  endtask

  task automatic test_reset_midflight();
    bus.grant_in = 8'hFF;
    tick();
    bus.grant_in = 8'h00;
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    for (int c = 2; c <= 5; c++) begin
      checks++;
      if (bus.grant_out !== 8'h00 || bus.stall !== 8'h00 || cnt_dbg !== 16'h0000) begin
        errors++; $display("FAIL midflight_c%0d go %h stall %h cnt %h exp 00 00 0000", c, bus.grant_out, bus.stall, cnt_dbg);
      end
      tick();
    end
  endtask

  task automatic test_scan();
    logic [CHAIN-1:0] pat;
    for (int i = 0; i < CHAIN; i++) pat[i] = ((i % 4) != 1);
    // Preload ch1 to one outstanding grant.
    bus.grant_in = 8'h02;
    tick();
    bus.grant_in = 8'h00;
    tick();
    tick();
    tick();
    checks++;
    if (cnt_dbg !== 16'h0004) begin
      errors++; $display("FAIL scan_pre cnt %h exp 0004", cnt_dbg);
    end
    se = 1'b1;
    for (int e = 1; e <= 2 * CHAIN; e++) begin
      si = (e <= CHAIN) ? pat[e-1] : 1'b0;
      bus.credit_ret = (e % 2 == 1) ? 8'h03 : 8'h00;
      tick();
      if (e >= CHAIN) begin
        checks++;
        if (so !== pat[e-CHAIN]) begin
          errors++; $display("FAIL scan_so_e%0d got %b exp %b", e, so, pat[e-CHAIN]);
        end
      end
    end
    se = 1'b0;
    si = 1'b0;
    bus.credit_ret = 8'h00;
    tick();
    checks++;
    if (cnt_dbg !== 16'h0004) begin
      errors++; $display("FAIL scan_cnt_hold got %h exp 0004", cnt_dbg);
    end
    checks++;
    if ({bus.err_ovf, bus.err_unf} !== 2'b00) begin
      errors++; $display("FAIL scan_err got %b%b exp 00", bus.err_ovf, bus.err_unf);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_latency();
    test_saturation();
    test_simultaneous();
    test_underflow();
    test_reset_midflight();
    test_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
